// File: rtl/counter_pkg.sv
// Shared constants and parameter checks for the up/down modulo counter family.
//   DIR_UP / DIR_DN       : encodings of count_dir
//   MODE_WRAP / MODE_SAT  : encodings of sat_mode
//   modulo_legal()        : true when a WIDTH/MODULO pair is a usable configuration
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // Legal when 2 <= WIDTH <= 32 and 2 <= MODULO <= 2**WIDTH.
  function automatic bit modulo_legal(input int unsigned width, input longint unsigned modulo);
    if ((width < WIDTH_MIN) || (width > WIDTH_MAX)) begin
      return 1'b0;
    end
    return (modulo >= 64'd2) && (modulo <= (64'd1 << width));
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-value logic for the up/down modulo counter.
// Ports:
//   count_q      : current counter value
//   count_en     : count enable
//   count_dir    : DIR_UP / DIR_DN
//   load         : preset command, overrides counting
//   data_preset  : preset value
//   sat_mode     : MODE_WRAP / MODE_SAT
//   next_val     : value the counter register takes at the next edge (reset excluded)
//   carry        : up-limit event this cycle
//   borrow       : down-limit event this cycle
//   preset_valid : data_preset < MODULO
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH  = 4,
  parameter longint unsigned MODULO = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] count_q,
  input  logic             count_en,
  input  logic             count_dir,
  input  logic             load,
  input  logic [WIDTH-1:0] data_preset,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] next_val,
  output logic             carry,
  output logic             borrow,
  output logic             preset_valid
);

  localparam int unsigned        EW      = WIDTH + 1;
  localparam logic [EW-1:0]      MOD_EXT = EW'(MODULO);
  localparam logic [WIDTH-1:0]   MAX_VAL = WIDTH'(MODULO - 64'd1);

  logic [EW-1:0] inc_w;
  logic [EW-1:0] dec_w;
  logic          at_max;
  logic          at_min;

  // Arithmetic is one bit wider so MODULO itself is representable and
  // underflow below zero shows up in the extra bit.
  always_comb begin
    inc_w        = {1'b0, count_q} + EW'(1);
    dec_w        = {1'b0, count_q} - EW'(1);
    at_max       = (inc_w == MOD_EXT);
    at_min       = dec_w[WIDTH];
    preset_valid = ({1'b0, data_preset} < MOD_EXT);

    carry  = count_en & (count_dir == DIR_UP) & ~load & at_max;
    borrow = count_en & (count_dir == DIR_DN) & ~load & at_min;

    next_val = count_q;
    if (load) begin
      // Out-of-range presets clamp to the top of the range.
      next_val = preset_valid ? data_preset : MAX_VAL;
    end else if (count_en) begin
      if (count_dir == DIR_UP) begin
        if (at_max) begin
          next_val = (sat_mode == MODE_SAT) ? MAX_VAL : '0;
        end else begin
          next_val = inc_w[WIDTH-1:0];
        end
      end else begin
        if (at_min) begin
          next_val = (sat_mode == MODE_SAT) ? '0 : MAX_VAL;
        end else begin
          next_val = dec_w[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Synchronous up/down counter with programmable modulo, wrap/saturate mode,
// carry/borrow events, preset validation and a sticky overflow flag.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   count_en, count_dir : enable and direction (1 = up)
//   load, data_preset   : preset command and value (load beats counting)
//   sat_mode            : 0 = wrap at limits, 1 = saturate
//   clr_flags           : clears ovf_flag (a simultaneous limit event wins)
//   counter_out         : registered count, always < MODULO
//   carry_out/borrow_out: combinational limit events
//   preset_err          : registered one-cycle pulse after an out-of-range load
//   ovf_flag            : registered sticky limit-event flag
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULO    = 64'd1 << WIDTH,
  parameter longint unsigned RST_VALUE = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             count_dir,
  input  logic             load,
  input  logic [WIDTH-1:0] data_preset,
  input  logic             sat_mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] counter_out,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             preset_err,
  output logic             ovf_flag
);

  // Elaboration-time configuration checks.
  if (!modulo_legal(WIDTH, MODULO)) begin : g_bad_modulo
    $error("counter_updown_mod: illegal WIDTH/MODULO combination");
  end
  if (RST_VALUE >= MODULO) begin : g_bad_rst_value
    $error("counter_updown_mod: RST_VALUE must be below MODULO");
  end

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VALUE);

  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;
  logic             preset_err_q;
  logic             preset_err_d;
  logic             ovf_flag_q;
  logic             ovf_flag_d;
  logic [WIDTH-1:0] next_val;
  logic             carry;
  logic             borrow;
  logic             preset_valid;

  counter_next_calc #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next_calc (
    .count_q      (counter_q),
    .count_en     (count_en),
    .count_dir    (count_dir),
    .load         (load),
    .data_preset  (data_preset),
    .sat_mode     (sat_mode),
    .next_val     (next_val),
    .carry        (carry),
    .borrow       (borrow),
    .preset_valid (preset_valid)
  );

  // Next-state for the counter and status registers.
  always_comb begin
    counter_d    = next_val;
    preset_err_d = load & ~preset_valid;
    ovf_flag_d   = ovf_flag_q;
    if (carry || borrow) begin
      ovf_flag_d = 1'b1;
    end else if (clr_flags) begin
      ovf_flag_d = 1'b0;
    end
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q    <= RST_VAL;
      preset_err_q <= 1'b0;
      ovf_flag_q   <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      preset_err_q <= preset_err_d;
      ovf_flag_q   <= ovf_flag_d;
    end
  end

  assign counter_out = counter_q;
  assign carry_out   = carry;
  assign borrow_out  = borrow;
  assign preset_err  = preset_err_q;
  assign ovf_flag    = ovf_flag_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed testbench for counter_updown_mod (WIDTH=4, MODULO=10, RST_VALUE=0).
// A modulo-arithmetic reference model is checked on every falling edge; literal
// expectations at key points pin the model itself.
module tb_counter_updown_mod;

  localparam int unsigned WIDTH = 4;
  localparam int          M     = 10;

  logic             clk;
  logic             rst;
  logic             count_en;
  logic             count_dir;
  logic             load;
  logic [WIDTH-1:0] data_preset;
  logic             sat_mode;
  logic             clr_flags;
  logic [WIDTH-1:0] counter_out;
  logic             carry_out;
  logic             borrow_out;
  logic             preset_err;
  logic             ovf_flag;

  int vectors;
  int miscompares;

  // Reference model state
  int m_cnt;
  int m_ovf;
  int m_perr;
  bit m_valid;

  counter_updown_mod #(
    .WIDTH     (WIDTH),
    .MODULO    (64'd10),
    .RST_VALUE (64'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count_en    (count_en),
    .count_dir   (count_dir),
    .load        (load),
    .data_preset (data_preset),
    .sat_mode    (sat_mode),
    .clr_flags   (clr_flags),
    .counter_out (counter_out),
    .carry_out   (carry_out),
    .borrow_out  (borrow_out),
    .preset_err  (preset_err),
    .ovf_flag    (ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected combinational events from current inputs and modelled count.
  function automatic int exp_carry();
    return (count_en && count_dir && !load && m_cnt == M - 1) ? 1 : 0;
  endfunction

  function automatic int exp_borrow();
    return (count_en && !count_dir && !load && m_cnt == 0) ? 1 : 0;
  endfunction

  // Reference model: plain modulo / min / max arithmetic.
  always @(posedge clk) begin
    int ev;
    if (rst) begin
      m_cnt   = 0;
      m_ovf   = 0;
      m_perr  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      ev     = exp_carry() | exp_borrow();
      m_perr = (load && int'(data_preset) >= M) ? 1 : 0;
      if (load) begin
        m_cnt = (int'(data_preset) < M) ? int'(data_preset) : M - 1;
      end else if (count_en) begin
        if (count_dir) begin
          m_cnt = sat_mode ? ((m_cnt + 1 > M - 1) ? M - 1 : m_cnt + 1) : (m_cnt + 1) % M;
        end else begin
          m_cnt = sat_mode ? ((m_cnt - 1 < 0) ? 0 : m_cnt - 1) : (m_cnt + M - 1) % M;
        end
      end
      if (ev != 0) m_ovf = 1;
      else if (clr_flags) m_ovf = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_counter", int'(counter_out), m_cnt);
      check("model_carry", int'(carry_out), exp_carry());
      check("model_borrow", int'(borrow_out), exp_borrow());
      check("model_preset_err", int'(preset_err), m_perr);
      check("model_ovf", int'(ovf_flag), m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ctl(input logic en, input logic dir, input logic ld,
                         input logic [WIDTH-1:0] pre, input logic sat, input logic clr);
    count_en    = en;
    count_dir   = dir;
    load        = ld;
    data_preset = pre;
    sat_mode    = sat;
    clr_flags   = clr;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_valid     = 1'b0;
    m_cnt       = 0;
    m_ovf       = 0;
    m_perr      = 0;
    rst         = 1'b1;
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    ticks(2);
    check("reset_counter", int'(counter_out), 0);
    check("reset_preset_err", int'(preset_err), 0);
    check("reset_ovf", int'(ovf_flag), 0);
    rst = 1'b0;

    // 1: count to 7, then reset mid-count with counting still enabled
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    ticks(7);
    check("t1_count7", int'(counter_out), 7);
    rst = 1'b1;
    tick();
    check("t1_rst_counter", int'(counter_out), 0);
    check("t1_rst_ovf", int'(ovf_flag), 0);
    check("t1_rst_perr", int'(preset_err), 0);
    tick();
    check("t1_rst_hold", int'(counter_out), 0);
    rst = 1'b0;

    // 2: wrap-mode count 0..9,0,1
    ticks(9);
    check("t2_at9", int'(counter_out), 9);
    check("t2_carry_at9", int'(carry_out), 1);
    check("t2_ovf_before", int'(ovf_flag), 0);
    tick();
    check("t2_wrap0", int'(counter_out), 0);
    check("t2_carry_at0", int'(carry_out), 0);
    check("t2_ovf_after", int'(ovf_flag), 1);
    tick();
    check("t2_then1", int'(counter_out), 1);

    // 3: load 0, count down in wrap mode then saturate mode
    set_ctl(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("t3_borrow_at0", int'(borrow_out), 1);
    tick();
    check("t3_wrap9", int'(counter_out), 9);
    tick();
    check("t3_then8", int'(counter_out), 8);
    set_ctl(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    set_ctl(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    ticks(2);
    check("t3_sat_hold0", int'(counter_out), 0);
    check("t3_sat_borrow", int'(borrow_out), 1);

    // 4: saturate at 9 counting up, then clear flags while idle
    set_ctl(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    ticks(3);
    check("t4_sat_hold9", int'(counter_out), 9);
    check("t4_sat_carry", int'(carry_out), 1);
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    check("t4_idle_no_carry", int'(carry_out), 0);
    tick();
    check("t4_clr_ovf", int'(ovf_flag), 0);
    check("t4_idle_hold", int'(counter_out), 9);

    // 5: invalid preset clamps and pulses preset_err; valid preset clears it
    set_ctl(1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
    tick();
    check("t5_clamp9", int'(counter_out), 9);
    check("t5_perr", int'(preset_err), 1);
    set_ctl(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    check("t5_load5", int'(counter_out), 5);
    check("t5_perr_clear", int'(preset_err), 0);
    set_ctl(1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0);
    tick();
    check("t5_hold5", int'(counter_out), 5);

    // 6: clr_flags coincident with a wrap event; set wins
    set_ctl(1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    check("t6_wrap0", int'(counter_out), 0);
    check("t6_set_wins", int'(ovf_flag), 1);
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
